// File: rtl/fft_iter_core.sv
// Iterative in-place radix-2 DIT FFT: bit-reversed load, LOG2N butterfly passes, natural-order unload.
// Define FFT_ITER_STAGE_SCALE_EN to halve after every stage instead of the final inverse divide by N.
module fft_iter_core #(
    parameter int N  = 16,
    parameter int W  = 16,
    parameter int TW = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic signed [W-1:0]           in_re,
    input  logic signed [W-1:0]           in_im,
    input  logic                          inv,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic signed [W+$clog2(N)-1:0] out_re,
    output logic signed [W+$clog2(N)-1:0] out_im,
    output logic                          busy
);
    localparam int LOG2N = $clog2(N);
    localparam int OW    = W + LOG2N;
    localparam int HALF  = N / 2;
    localparam int QN    = N / 4;
    localparam int QW    = $clog2(QN + 1);
    localparam int PW    = OW + TW + 1;

    typedef enum logic [1:0] {LOAD, COMPUTE, UNLOAD} state_t;

    state_t            state_q, state_d;
    logic [LOG2N-1:0]  cnt_q, cnt_d, cyc_q, cyc_d;
    logic [3:0]        stage_q, stage_d;
    logic              inv_q, inv_d, run_q;

    logic signed [OW-1:0] mem_re [N];
    logic signed [OW-1:0] mem_im [N];
    logic signed [TW-1:0] qrom [0:QN];

    // Quarter-wave cosine table; cos(0) clamps to the largest positive Q1.(TW-1) code.
    for (genvar g = 0; g <= QN; g++) begin : g_rom
        localparam real SC = (2.0 ** (TW - 1)) * $cos(6.283185307179586 * g / N);
        localparam int  QV = (g == 0) ? (2 ** (TW - 1)) - 1 : $rtoi(SC + 0.5);
        assign qrom[g] = TW'(QV);
    end

    function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] v);
        logic [LOG2N-1:0] r;
        r = '0;
        for (int i = 0; i < LOG2N; i++) r[i] = v[LOG2N-1-i];
        return r;
    endfunction

    function automatic logic signed [OW-1:0] rnd(input logic signed [PW-1:0] p);
        logic signed [PW-1:0] s;
        s = p + PW'(2 ** (TW - 2));
        return OW'(s >>> (TW - 1));
    endfunction

    function automatic logic signed [OW-1:0] stage_out(input logic signed [OW-1:0] v);
`ifdef FFT_ITER_STAGE_SCALE_EN
        return v >>> 1;
`else
        return v;
`endif
    endfunction

    logic load_acc, issue;
    assign in_ready  = run_q && (state_q == LOAD);
    assign load_acc  = in_valid && in_ready;
    assign busy      = (state_q == COMPUTE);
    assign out_valid = (state_q == UNLOAD);
    assign issue     = (state_q == COMPUTE) && (cyc_q < LOG2N'(HALF));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= LOAD;
            cnt_q   <= '0;
            cyc_q   <= '0;
            stage_q <= '0;
            inv_q   <= 1'b0;
            run_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cyc_q   <= cyc_d;
            stage_q <= stage_d;
            inv_q   <= inv_d;
            run_q   <= 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cyc_d   = cyc_q;
        stage_d = stage_q;
        inv_d   = inv_q;
        case (state_q)
            LOAD: if (load_acc) begin
                if (cnt_q == '0) inv_d = inv;
                cnt_d = cnt_q + LOG2N'(1);
                if (cnt_q == LOG2N'(N - 1)) state_d = COMPUTE;
            end
            // Each pass issues HALF butterflies then drains the 2-deep pipeline.
            COMPUTE: if (cyc_q == LOG2N'(HALF + 1)) begin
                cyc_d = '0;
                if (stage_q == 4'(LOG2N - 1)) begin
                    stage_d = '0;
                    state_d = UNLOAD;
                end else begin
                    stage_d = stage_q + 4'd1;
                end
            end else begin
                cyc_d = cyc_q + LOG2N'(1);
            end
            UNLOAD: if (out_ready) begin
                cnt_d = cnt_q + LOG2N'(1);
                if (cnt_q == LOG2N'(N - 1)) state_d = LOAD;
            end
            default: state_d = LOAD;
        endcase
    end

    // p0: butterfly addressing and twiddle lookup
    logic [LOG2N-1:0]     hf, mask_lo, a_addr, b_addr, k_idx;
    logic [QW-1:0]        ci, si;
    logic signed [TW-1:0] cs, sn;
    always_comb begin
        hf      = LOG2N'(1) << stage_q;
        mask_lo = hf - LOG2N'(1);
        a_addr  = ((cyc_q & ~mask_lo) << 1) | (cyc_q & mask_lo);
        b_addr  = a_addr | hf;
        k_idx   = (cyc_q & mask_lo) << (4'(LOG2N - 1) - stage_q);
        if (k_idx < LOG2N'(QN)) begin
            ci = QW'(k_idx);
            si = QW'(LOG2N'(QN) - k_idx);
            cs = qrom[ci];
        end else begin
            ci = QW'(LOG2N'(HALF) - k_idx);
            si = QW'(k_idx - LOG2N'(QN));
            cs = -qrom[ci];
        end
        sn = qrom[si];
    end

    logic                 vld_p1_q, vld_p2_q;
    logic [LOG2N-1:0]     aa_p1_q, ab_p1_q, aa_p2_q, ab_p2_q;
    logic signed [OW-1:0] ar_p1_q, ai_p1_q, br_p1_q, bi_p1_q;
    logic signed [TW-1:0] wr_p1_q, wi_p1_q;
    logic signed [OW-1:0] ar_p2_q, ai_p2_q, tr_p2_q, ti_p2_q;
    logic signed [PW-1:0] pr, pi;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1_q <= 1'b0;
            vld_p2_q <= 1'b0;
        end else begin
            vld_p1_q <= issue;
            vld_p2_q <= vld_p1_q;
        end
    end

    // p1: operands latched; complex multiply t = B*w
    always_comb begin
        pr = PW'(br_p1_q) * PW'(wr_p1_q) - PW'(bi_p1_q) * PW'(wi_p1_q);
        pi = PW'(br_p1_q) * PW'(wi_p1_q) + PW'(bi_p1_q) * PW'(wr_p1_q);
    end

    always_ff @(posedge clk) begin
        aa_p1_q <= a_addr;
        ab_p1_q <= b_addr;
        ar_p1_q <= mem_re[a_addr];
        ai_p1_q <= mem_im[a_addr];
        br_p1_q <= mem_re[b_addr];
        bi_p1_q <= mem_im[b_addr];
        wr_p1_q <= cs;
        wi_p1_q <= inv_q ? sn : -sn;
        aa_p2_q <= aa_p1_q;
        ab_p2_q <= ab_p1_q;
        ar_p2_q <= ar_p1_q;
        ai_p2_q <= ai_p1_q;
        tr_p2_q <= rnd(pr);
        ti_p2_q <= rnd(pi);
    end

    // p2: A' = A+t, B' = A-t written back in place
    always_ff @(posedge clk) begin
        if (load_acc) begin
            mem_re[bitrev(cnt_q)] <= OW'(in_re);
            mem_im[bitrev(cnt_q)] <= OW'(in_im);
        end else if (vld_p2_q) begin
            mem_re[aa_p2_q] <= stage_out(ar_p2_q + tr_p2_q);
            mem_im[aa_p2_q] <= stage_out(ai_p2_q + ti_p2_q);
            mem_re[ab_p2_q] <= stage_out(ar_p2_q - tr_p2_q);
            mem_im[ab_p2_q] <= stage_out(ai_p2_q - ti_p2_q);
        end
    end

    logic signed [OW-1:0] rd_re, rd_im;
    always_comb begin
        rd_re = mem_re[cnt_q];
        rd_im = mem_im[cnt_q];
`ifndef FFT_ITER_STAGE_SCALE_EN
        if (inv_q) begin
            rd_re = rd_re >>> LOG2N;
            rd_im = rd_im >>> LOG2N;
        end
`endif
        out_re = out_valid ? rd_re : '0;
        out_im = out_valid ? rd_im : '0;
    end

endmodule

// File: tb/tb_fft_iter_core.sv
// Directed bench for fft_iter_core at N=8: impulse, DC, inverse, shifted impulse with backpressure, mid-COMPUTE reset.
module tb_fft_iter_core;
    localparam int N  = 8;
    localparam int OW = 19;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b1;
    logic                 in_valid = 1'b0;
    logic                 in_ready;
    logic signed [15:0]   in_re = '0;
    logic signed [15:0]   in_im = '0;
    logic                 inv = 1'b0;
    logic                 out_valid;
    logic                 out_ready = 1'b1;
    logic signed [OW-1:0] out_re;
    logic signed [OW-1:0] out_im;
    logic                 busy;

    int errs = 0;
    int checks = 0;
    int xr[N], xi[N], er[N], ei[N];

    fft_iter_core #(.N(N), .W(16), .TW(16)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_re(in_re), .in_im(in_im), .inv(inv), .out_valid(out_valid),
        .out_ready(out_ready), .out_re(out_re), .out_im(out_im), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        if (obs !== exp) begin
            errs++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fill(input int a0, input int arest, input int e0, input int erest);
        for (int i = 0; i < N; i++) begin
            xr[i] = (i == 0) ? a0 : arest;
            xi[i] = 0;
            er[i] = (i == 0) ? e0 : erest;
            ei[i] = 0;
        end
    endtask

    task automatic send_frame(input logic iv);
        int guard;
        for (int i = 0; i < N; i++) begin
            in_valid = 1'b1;
            in_re = 16'(xr[i]);
            in_im = 16'(xi[i]);
            inv = iv;
            guard = 0;
            while (!in_ready && guard < 100) begin
                tick();
                guard++;
            end
            if (guard >= 100) check("in_ready_timeout", 0, 1);
            tick();
        end
        in_valid = 1'b0;
        inv = 1'b0;
        in_re = '0;
        in_im = '0;
    endtask

    task automatic wait_compute();
        int cnt, guard;
        cnt = 0;
        guard = 0;
        check("out_re_zero_compute", int'(out_re), 0);
        check("in_ready_compute", int'(in_ready), 0);
        while (!out_valid && guard < 500) begin
            if (busy) cnt++;
            tick();
            guard++;
        end
        check("busy_cycles", cnt, 18);
    endtask

    task automatic recv_frame(input int stall_bin);
        int guard;
        for (int b = 0; b < N; b++) begin
            guard = 0;
            while (!out_valid && guard < 100) begin
                tick();
                guard++;
            end
            check($sformatf("bin%0d_re", b), int'(out_re), er[b]);
            check($sformatf("bin%0d_im", b), int'(out_im), ei[b]);
            if (b == stall_bin) begin
                out_ready = 1'b0;
                for (int s = 0; s < 2; s++) begin
                    tick();
                    check($sformatf("stall%0d_valid", s), int'(out_valid), 1);
                    check($sformatf("stall%0d_re", s), int'(out_re), er[b]);
                    check($sformatf("stall%0d_im", s), int'(out_im), ei[b]);
                end
                out_ready = 1'b1;
            end
            tick();
        end
        check("out_valid_after", int'(out_valid), 0);
        check("in_ready_after", int'(in_ready), 1);
    endtask

    task automatic run_frame(input logic iv, input int stall_bin);
        send_frame(iv);
        wait_compute();
        recv_frame(stall_bin);
    endtask

    initial begin
        #2 rst_n = 1'b0;
        #1;
        check("rst_in_ready", int'(in_ready), 0);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_out_re", int'(out_re), 0);
        tick();
        tick();
        rst_n = 1'b1;
        check("rel_in_ready_low", int'(in_ready), 0);
        tick();
        check("rel_in_ready_high", int'(in_ready), 1);

`ifdef FFT_ITER_STAGE_SCALE_EN
        fill(1000, 0, 125, 125);
        run_frame(1'b0, -1);
        fill(8, 8, 8, 0);
        run_frame(1'b0, 0);
`else
        fill(1000, 0, 1000, 1000);
        run_frame(1'b0, -1);
        fill(1, 1, 8, 0);
        run_frame(1'b0, -1);
        // x[n] = 1000*delta[n-1]: X[k] = 1000*exp(-j*pi*k/4), products rounded half-up.
        for (int i = 0; i < N; i++) begin
            xr[i] = (i == 1) ? 1000 : 0;
            xi[i] = 0;
        end
        er = '{1000, 707, 0, -707, -1000, -707, 0, 707};
        ei = '{0, -707, -1000, -707, 0, 707, 1000, 707};
        run_frame(1'b0, 2);
`endif
        fill(8, 0, 1, 1);
        run_frame(1'b1, -1);

        fill(1000, 0, 1000, 1000);
`ifdef FFT_ITER_STAGE_SCALE_EN
        fill(1000, 0, 125, 125);
`endif
        send_frame(1'b0);
        for (int i = 0; i < 5; i++) tick();
        check("mid_busy", int'(busy), 1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_busy", int'(busy), 0);
        check("mid_rst_out_valid", int'(out_valid), 0);
        check("mid_rst_out_re", int'(out_re), 0);
        check("mid_rst_out_im", int'(out_im), 0);
        check("mid_rst_in_ready", int'(in_ready), 0);
        tick();
        rst_n = 1'b1;
        tick();
        check("mid_rel_in_ready", int'(in_ready), 1);
        run_frame(1'b0, -1);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got 0, expected 1");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/fft_iter_core.md
FFT_ITER_CORE -- requirements
Module: fft_iter_core

Interface
REQ-001 SHALL have parameter N, default 16, points per frame; power of two, 4..1024.
REQ-002 SHALL have parameter W, default 16, signed input sample width per component.
REQ-003 SHALL have parameter TW, default 16, signed twiddle width, format Q1.(TW-1).
REQ-004 SHALL derive localparam LOG2N = clog2(N) and OW = W+LOG2N, the output width.
REQ-005 SHALL have port clk, input, 1, the single clock; all state on its rising edge.
REQ-006 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-007 SHALL have port in_valid, input, 1, input sample valid.
REQ-008 SHALL have port in_ready, output, 1, core accepts an input sample.
REQ-009 SHALL have ports in_re and in_im, input, W each, signed sample, natural order.
REQ-010 SHALL have port inv, input, 1, 1 = inverse transform; sampled with a frame's first accepted sample.
REQ-011 SHALL have port out_valid, output, 1, output sample valid.
REQ-012 SHALL have port out_ready, input, 1, downstream accepts output.
REQ-013 SHALL have ports out_re and out_im, output, OW each, signed result, natural bin order.
REQ-014 SHALL have port busy, output, 1, high in COMPUTE.

Function
REQ-015 SHALL run FSM LOAD -> COMPUTE -> UNLOAD -> LOAD; no other states.
REQ-016 In LOAD: in_ready=1; each in_valid&in_ready cycle writes one sample at bit-reversed address of load count; after sample N-1, next state COMPUTE.
REQ-017 Samples SHALL be sign-extended to OW on write; all internal arithmetic at OW bits, no saturation; wrap is acceptable because growth is bounded by LOG2N bits.
REQ-018 COMPUTE SHALL run LOG2N stages, each N/2 radix-2 DIT butterflies issued one per cycle, in-place, with a 2-cycle butterfly pipeline.
REQ-019 COMPUTE SHALL last exactly LOG2N*(N/2+2) cycles; each stage waits for its last write before the next stage starts.
REQ-020 Butterfly: t = B*w, A' = A+t, B' = A-t; w = exp(-j2πk/N), conjugated when latched inv=1.
REQ-021 Products SHALL round half-up: add 2^(TW-2), then arithmetic shift right by TW-1.
REQ-022 Twiddles SHALL come from an internal quarter-wave cos/sin ROM, values round(2^(TW-1)*cos), with +1.0 clamped to 2^(TW-1)-1.
REQ-023 When inv=1, final results SHALL be arithmetic-shifted right by LOG2N (divide by N, floor) before output.
REQ-024 UNLOAD SHALL present bins 0..N-1 in order; out_valid=1; data SHALL be held stable while out_ready=0; index advances only on out_valid&out_ready.
REQ-025 After bin N-1 handshakes, next state LOAD; in_ready rises the following cycle, with no overlap of frames.
REQ-026 in_ready=0 in COMPUTE and UNLOAD; in_valid is ignored there.
REQ-027 out_valid=0 outside UNLOAD; out_re/out_im SHALL be 0 when out_valid=0.

Reset
REQ-028 rst_n low SHALL force LOAD, counters 0, latched inv 0, in_ready=0 while asserted, out_valid=0, busy=0, out_re=out_im=0.
REQ-029 in_ready SHALL become 1 on the first clock edge after rst_n deasserts.
REQ-030 Reset in any state SHALL abort the frame; partial data is discarded; sample memory need not be cleared.

Configuration
REQ-031 Macro FFT_ITER_STAGE_SCALE_EN defined: every stage SHALL shift A' and B' right by 1 (floor), forward output = DFT/N, and the REQ-023 inverse shift SHALL NOT be applied.
REQ-032 Macro FFT_ITER_STAGE_SCALE_EN undefined: no per-stage scaling; REQ-023 applies.

Verification
REQ-033 Impulse test: N=8, forward, x[0]=1000, rest 0 -> all 8 bins re=1000, im=0.
REQ-034 DC test: N=8, forward, all x=1+0j -> X[0]=8, X[1..7]=0 (both components).
REQ-035 Inverse test: N=8, inv=1, X[0]=8, rest 0 -> all outputs re=1, im=0.
REQ-036 Backpressure test: out_ready toggled 1-0-0-1 during UNLOAD -> no bin lost or duplicated; data stable while stalled; busy high for exactly 3*(4+2)=18 cycles.
REQ-037 Mid-COMPUTE reset test: rst_n pulsed low mid-COMPUTE -> outputs 0 during reset; next full frame yields correct results.
REQ-038 Scaling test: with FFT_ITER_STAGE_SCALE_EN defined, N=8, all x=8 -> X[0]=8, X[1..7]=0.
